// File: rtl/mig_cmd_arbiter.sv
// Two-requester round-robin command arbiter in front of a MIG command port.
// Each requester owns a 2-deep command queue; one command issues at most every other cycle.
module mig_cmd_arbiter #(
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  enable,
  input  logic                  req0_cmd_en,
  input  logic [2:0]            req0_cmd_instr,
  input  logic [5:0]            req0_cmd_bl,
  input  logic [ADDR_WIDTH-1:0] req0_cmd_byte_addr,
  output logic                  req0_cmd_full,
  output logic                  req0_overflow,
  output logic [15:0]           req0_issued,
  input  logic                  req1_cmd_en,
  input  logic [2:0]            req1_cmd_instr,
  input  logic [5:0]            req1_cmd_bl,
  input  logic [ADDR_WIDTH-1:0] req1_cmd_byte_addr,
  output logic                  req1_cmd_full,
  output logic                  req1_overflow,
  output logic [15:0]           req1_issued,
  output logic                  mig_cmd_en,
  output logic [2:0]            mig_cmd_instr,
  output logic [5:0]            mig_cmd_bl,
  output logic [ADDR_WIDTH-1:0] mig_cmd_byte_addr,
  input  logic                  mig_cmd_full,
  output logic                  busy
);

  localparam int EW = 9 + ADDR_WIDTH;

  logic [EW-1:0] mem [2][2];
  logic [EW-1:0] push_data [2];
  logic [EW-1:0] head [2];
  logic [1:0]    cnt [2];
  logic [15:0]   issued_cnt [2];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [1:0]    push_en, nonempty, full, accept, drop, pop, overflow;
  logic          issue, grant, last_grant;

  assign push_en      = {req1_cmd_en, req0_cmd_en};
  assign push_data[0] = {req0_cmd_instr, req0_cmd_bl, req0_cmd_byte_addr};
  assign push_data[1] = {req1_cmd_instr, req1_cmd_bl, req1_cmd_byte_addr};

  assign nonempty = {cnt[1] != 2'd0, cnt[0] != 2'd0};
  assign full     = {cnt[1] == 2'd2, cnt[0] == 2'd2};
  assign head[0]  = mem[0][rd_ptr[0]];
  assign head[1]  = mem[1][rd_ptr[1]];

  // Waiting out the cycle after an issue keeps mig_cmd_full's one-cycle lag harmless.
  assign issue = enable && !mig_cmd_full && !mig_cmd_en && (|nonempty);
  assign grant = (&nonempty) ? ~last_grant : nonempty[1];
  assign pop   = issue ? (grant ? 2'b10 : 2'b01) : 2'b00;

  // A full queue that is being popped this cycle can still take a push.
  assign accept = enable ? (push_en & (~full | pop)) : 2'b00;
  assign drop   = enable ? (push_en & full & ~pop)   : 2'b00;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) mem[i][wr_ptr[i]] <= push_data[i];
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i]        <= '0;
        issued_cnt[i] <= '0;
      end
    end else if (!enable) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i]        <= '0;
        issued_cnt[i] <= '0;
      end
    end else begin
      wr_ptr   <= wr_ptr ^ accept;
      rd_ptr   <= rd_ptr ^ pop;
      overflow <= overflow | drop;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= cnt[i] + {1'b0, accept[i]} - {1'b0, pop[i]};
        if (pop[i]) issued_cnt[i] <= issued_cnt[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mig_cmd_en        <= 1'b0;
      mig_cmd_instr     <= '0;
      mig_cmd_bl        <= '0;
      mig_cmd_byte_addr <= '0;
      last_grant        <= 1'b0;
    end else if (!enable) begin
      mig_cmd_en <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      mig_cmd_en <= issue;
      if (issue) begin
        {mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr} <= head[grant];
        last_grant <= grant;
      end
    end
  end

  assign req0_cmd_full = full[0];
  assign req1_cmd_full = full[1];
  assign req0_overflow = overflow[0];
  assign req1_overflow = overflow[1];
  assign req0_issued   = issued_cnt[0];
  assign req1_issued   = issued_cnt[1];
  assign busy          = (|nonempty) || mig_cmd_en;

endmodule

// File: tb/tb_mig_cmd_arbiter.sv
// Bench for mig_cmd_arbiter: expected commands queue up as they are pushed and a
// monitor pops and compares them whenever mig_cmd_en is seen high.
module tb_mig_cmd_arbiter;
  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          enable = 1'b1;
  logic          req0_cmd_en = 1'b0, req1_cmd_en = 1'b0;
  logic [2:0]    req0_cmd_instr = '0, req1_cmd_instr = '0;
  logic [5:0]    req0_cmd_bl = '0, req1_cmd_bl = '0;
  logic [AW-1:0] req0_cmd_byte_addr = '0, req1_cmd_byte_addr = '0;
  logic          req0_cmd_full, req1_cmd_full, req0_overflow, req1_overflow;
  logic [15:0]   req0_issued, req1_issued;
  logic          mig_cmd_en;
  logic [2:0]    mig_cmd_instr;
  logic [5:0]    mig_cmd_bl;
  logic [AW-1:0] mig_cmd_byte_addr;
  logic          mig_cmd_full = 1'b0;
  logic          busy;

  mig_cmd_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetb(resetb), .enable(enable),
    .req0_cmd_en(req0_cmd_en), .req0_cmd_instr(req0_cmd_instr), .req0_cmd_bl(req0_cmd_bl),
    .req0_cmd_byte_addr(req0_cmd_byte_addr), .req0_cmd_full(req0_cmd_full),
    .req0_overflow(req0_overflow), .req0_issued(req0_issued),
    .req1_cmd_en(req1_cmd_en), .req1_cmd_instr(req1_cmd_instr), .req1_cmd_bl(req1_cmd_bl),
    .req1_cmd_byte_addr(req1_cmd_byte_addr), .req1_cmd_full(req1_cmd_full),
    .req1_overflow(req1_overflow), .req1_issued(req1_issued),
    .mig_cmd_en(mig_cmd_en), .mig_cmd_instr(mig_cmd_instr), .mig_cmd_bl(mig_cmd_bl),
    .mig_cmd_byte_addr(mig_cmd_byte_addr), .mig_cmd_full(mig_cmd_full), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    instr;
    logic [5:0]    bl;
    logic [AW-1:0] addr;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t mon_exp;
  int   vectors = 0;
  int   miscompares = 0;
  int   en_seen = 0;

  function automatic cmd_t mk(input logic [2:0] instr, input logic [5:0] bl, input logic [AW-1:0] addr);
    cmd_t c;
    c.instr = instr;
    c.bl    = bl;
    c.addr  = addr;
    return c;
  endfunction

  always @(negedge clk) begin
    if (resetb === 1'b1 && mig_cmd_en === 1'b1) begin
      en_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_issue: got %h, required no issue",
                 {mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr} !== mon_exp) begin
          miscompares++;
          $display("FAIL issued_cmd: got %h, required %h",
                   {mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr}, mon_exp);
        end
      end
    end
  end

  task automatic push_cmd(input int r, input cmd_t c);
    if (r == 0) begin
      req0_cmd_en = 1'b1; req0_cmd_instr = c.instr; req0_cmd_bl = c.bl; req0_cmd_byte_addr = c.addr;
    end else begin
      req1_cmd_en = 1'b1; req1_cmd_instr = c.instr; req1_cmd_bl = c.bl; req1_cmd_byte_addr = c.addr;
    end
  endtask

  task automatic idle_push();
    req0_cmd_en = 1'b0;
    req1_cmd_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_mig: got %h, required 0", {mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr});
    end
    vectors++;
    if ({req0_cmd_full, req1_cmd_full, req0_overflow, req1_overflow, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 00000",
               {req0_cmd_full, req1_cmd_full, req0_overflow, req1_overflow, busy});
    end
    vectors++;
    if ({req0_issued, req1_issued} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_issued: got %h, required 0", {req0_issued, req1_issued});
    end
    resetb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    cmd_t c;
    c = mk(3'd0, 6'd15, 30'h40);
    push_cmd(0, c);
    exp_q.push_back(c);
    @(negedge clk);
    idle_push();
    vectors++;
    if (mig_cmd_en !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_latency1: got en=%b busy=%b, required en=0 busy=1", mig_cmd_en, busy);
    end
    @(negedge clk);
    vectors++;
    if (mig_cmd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL single_latency2: got en=%b, required 1", mig_cmd_en);
    end
    vectors++;
    if (req0_issued !== 16'd1 || req1_issued !== 16'd0) begin
      miscompares++;
      $display("FAIL single_issued: got %0d/%0d, required 1/0", req0_issued, req1_issued);
    end
    @(negedge clk);
    vectors++;
    if ({mig_cmd_en, busy, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr} !== {2'b00, c}) begin
      miscompares++;
      $display("FAIL single_hold: got en=%b busy=%b fields=%h, required en=0 busy=0 fields=%h",
               mig_cmd_en, busy, {mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr}, c);
    end
  endtask

  task automatic test_round_robin();
    cmd_t a0, a1, b0, b1;
    logic [7:0] pat;
    a0 = mk(3'd1, 6'd3, 30'h100); a1 = mk(3'd1, 6'd7, 30'h180);
    b0 = mk(3'd0, 6'd1, 30'h2000); b1 = mk(3'd0, 6'd63, 30'h2040);
    mig_cmd_full = 1'b1;
    push_cmd(0, a0); push_cmd(1, b0);
    @(negedge clk);
    push_cmd(0, a1); push_cmd(1, b1);
    @(negedge clk);
    idle_push();
    vectors++;
    if ({req0_cmd_full, req1_cmd_full} !== 2'b11) begin
      miscompares++;
      $display("FAIL rr_full: got %b, required 11", {req0_cmd_full, req1_cmd_full});
    end
    exp_q.push_back(b0); exp_q.push_back(a0); exp_q.push_back(b1); exp_q.push_back(a1);
    mig_cmd_full = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat[k] = mig_cmd_en;
    end
    vectors++;
    if (pat !== 8'b0101_0101 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_spacing: got pattern=%b busy=%b, required 01010101 busy=0", pat, busy);
    end
    vectors++;
    if (req0_issued !== 16'd3 || req1_issued !== 16'd2 || req0_overflow !== 1'b0 || req1_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_counts: got %0d/%0d ovf=%b%b, required 3/2 ovf=00",
               req0_issued, req1_issued, req0_overflow, req1_overflow);
    end
  endtask

  task automatic test_full_hold();
    cmd_t c0, c1;
    int bad;
    c0 = mk(3'd2, 6'd9, 30'h3000); c1 = mk(3'd3, 6'd10, 30'h3008);
    push_cmd(0, c0); exp_q.push_back(c0);
    @(negedge clk);
    push_cmd(0, c1); exp_q.push_back(c1);
    mig_cmd_full = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      idle_push();
      if (mig_cmd_en !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL hold_no_issue: got %0d issue cycles, required 0", bad);
    end
    mig_cmd_full = 1'b0;
    @(negedge clk);
    vectors++;
    if (mig_cmd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: got en=%b, required 1", mig_cmd_en);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (req0_issued !== 16'd5 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_drain: got issued0=%0d busy=%b, required 5 busy=0", req0_issued, busy);
    end
  endtask

  task automatic test_back_to_back();
    cmd_t d [3];
    int start;
    d[0] = mk(3'd1, 6'd0, 30'h5000); d[1] = mk(3'd1, 6'd1, 30'h5010); d[2] = mk(3'd1, 6'd2, 30'h5020);
    mig_cmd_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_cmd(1, d[k]);
      if (k < 2) exp_q.push_back(d[k]);
      @(negedge clk);
    end
    idle_push();
    vectors++;
    if ({req1_overflow, req1_cmd_full, req0_overflow} !== 3'b110) begin
      miscompares++;
      $display("FAIL b2b_overflow: got ovf1=%b full1=%b ovf0=%b, required 1 1 0",
               req1_overflow, req1_cmd_full, req0_overflow);
    end
    mig_cmd_full = 1'b0;
    start = en_seen;
    repeat (6) @(negedge clk);
    vectors++;
    if (en_seen - start != 2 || req1_issued !== 16'd4) begin
      miscompares++;
      $display("FAIL b2b_issues: got %0d issues issued1=%0d, required 2 issued1=4",
               en_seen - start, req1_issued);
    end
  endtask

  task automatic test_enable_flush();
    cmd_t e0, e1, h0, h1;
    int bad;
    e0 = mk(3'd4, 6'd4, 30'h6000); e1 = mk(3'd4, 6'd5, 30'h6040);
    h0 = mk(3'd5, 6'd33, 30'h3ABC_D120); h1 = mk(3'd6, 6'd34, 30'h0123_4560);
    mig_cmd_full = 1'b1;
    push_cmd(0, e0);
    @(negedge clk);
    push_cmd(0, e1);
    @(negedge clk);
    idle_push();
    enable = 1'b0;
    push_cmd(1, mk(3'd7, 6'd7, 30'h7000));
    @(negedge clk);
    vectors++;
    if ({busy, req0_cmd_full, req1_overflow, mig_cmd_en} !== 4'b0 || {req0_issued, req1_issued} !== 32'd0) begin
      miscompares++;
      $display("FAIL flush_state: got busy=%b full0=%b ovf1=%b en=%b issued=%0d/%0d, required all 0",
               busy, req0_cmd_full, req1_overflow, mig_cmd_en, req0_issued, req1_issued);
    end
    mig_cmd_full = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mig_cmd_en !== 1'b0 || req1_overflow !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL flush_quiet: got %0d active cycles, required 0", bad);
    end
    idle_push();
    enable = 1'b1;
    @(negedge clk);
    // Pointer was cleared by the flush, so req1 wins the tie.
    push_cmd(0, h0); push_cmd(1, h1);
    exp_q.push_back(h1); exp_q.push_back(h0);
    @(negedge clk);
    idle_push();
    @(negedge clk);
    vectors++;
    if (mig_cmd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL reenable_issue: got en=%b, required 1", mig_cmd_en);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (req0_issued !== 16'd1 || req1_issued !== 16'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reenable_counts: got %0d/%0d busy=%b, required 1/1 busy=0",
               req0_issued, req1_issued, busy);
    end
  endtask

  task automatic test_reset_mid();
    cmd_t k;
    int bad;
    mig_cmd_full = 1'b1;
    push_cmd(0, mk(3'd2, 6'd20, 30'h8000)); push_cmd(1, mk(3'd3, 6'd21, 30'h9000));
    @(negedge clk);
    idle_push();
    #2 resetb = 1'b0;
    #1;
    vectors++;
    if ({mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr} !== '0 ||
        {req0_cmd_full, req1_cmd_full, req0_overflow, req1_overflow, busy} !== 5'b0 ||
        {req0_issued, req1_issued} !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_async: got en=%b fields=%h flags=%b issued=%0d/%0d, required all 0",
               mig_cmd_en, {mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr},
               {req0_cmd_full, req1_cmd_full, req0_overflow, req1_overflow, busy}, req0_issued, req1_issued);
    end
    @(negedge clk);
    resetb = 1'b1;
    mig_cmd_full = 1'b0;
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (mig_cmd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midreset_stale: got %0d active cycles, required 0", bad);
    end
    k = mk(3'd1, 6'd11, 30'hA000);
    push_cmd(0, k); exp_q.push_back(k);
    @(negedge clk);
    idle_push();
    @(negedge clk);
    vectors++;
    if (mig_cmd_en !== 1'b1 || req0_issued !== 16'd1) begin
      miscompares++;
      $display("FAIL midreset_recover: got en=%b issued0=%0d, required 1 1", mig_cmd_en, req0_issued);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_hold();
    test_back_to_back();
    test_enable_flush();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
